// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: reset PC, bubble instruction,
// instruction width and decode constants used by fetch and hazard logic.
package mips_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [5:0]  FUNCT_JR  = 6'b001000;

    // Action taken by the IF/ID pipeline register on a clock edge.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_BUBBLE = 2'd1,
        IFID_LOAD   = 2'd2
    } ifid_op_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, used for debug event counts.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise increment unless already all-ones.
    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage plus IF/ID register: owns the PC, addresses the synchronous
// IMEM one cycle ahead, and applies stall, flush-bubble and sticky halt.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_PC  = DATA_W'(mips_pkg::RESET_PC),
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(mips_pkg::NOP_INSTR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stallF,
    input  logic              stallD,
    input  logic              clear,
    input  logic              PCSrcD,
    input  logic              jump,
    input  logic [DATA_W-1:0] branch_target,
    input  logic [DATA_W-1:0] jump_target,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] pcF,
    output logic [DATA_W-1:0] instrD,
    output logic [DATA_W-1:0] pcplus4D,
    output logic              validD,
    output logic              halted,
    output logic [DATA_W-1:0] stall_cnt,
    output logic [DATA_W-1:0] flush_cnt
);

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] pcplus4_q, pcplus4_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic [DATA_W-1:0] pc_plus4;
    ifid_op_e          ifid_op;
    logic              stall_inc;
    logic              flush_inc;

    assign pc_plus4 = pc_q + DATA_W'(4);

    // Next PC: hold on stall/halt, else jump beats branch beats sequential.
    always_comb begin
        pc_d = pc_plus4;
        if (stallF || halted_q) begin
            pc_d = pc_q;
        end else if (jump) begin
            pc_d = jump_target;
        end else if (PCSrcD) begin
            pc_d = branch_target;
        end
    end

    // The RAM is addressed with the next PC so its registered output always
    // matches pcF; during reset it is primed with the reset PC.
    assign imem_addr = rst_n ? pc_d : RESET_PC;

    // IF/ID action select and next values: hold beats bubble beats load.
    always_comb begin
        if (stallD || halted_q) begin
            ifid_op = IFID_HOLD;
        end else if (clear) begin
            ifid_op = IFID_BUBBLE;
        end else begin
            ifid_op = IFID_LOAD;
        end

        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        case (ifid_op)
            IFID_BUBBLE: begin
                instr_d   = NOP_INSTR;
                pcplus4_d = pc_plus4;
                valid_d   = 1'b0;
            end
            IFID_LOAD: begin
                instr_d   = imem_rdata;
                pcplus4_d = pc_plus4;
                valid_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Halt is requested by asserting all three hazard controls together and
    // persists until reset.
    assign halted_d  = halted_q || (stallF && stallD && clear);

    assign stall_inc = stallF && !halted_q;
    assign flush_inc = (ifid_op == IFID_BUBBLE);

    // PC, IF/ID and halt state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            pcplus4_q <= RESET_PC + DATA_W'(4);
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
        end
    end

    sat_counter #(.WIDTH(DATA_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (stall_inc),
        .clear_i (1'b0),
        .count_o (stall_cnt)
    );

    sat_counter #(.WIDTH(DATA_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (flush_inc),
        .clear_i (1'b0),
        .count_o (flush_cnt)
    );

    assign pcF      = pc_q;
    assign instrD   = instr_q;
    assign pcplus4D = pcplus4_q;
    assign validD   = valid_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random
// stimulus against a behavioural model; a narrow instance covers saturation.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallF, stallD, clear, PCSrcD, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] pcF, instrD, pcplus4D, stall_cnt, flush_cnt;
    logic        validD, halted;

    // Narrow instance so counter saturation and PC wrap are reachable quickly.
    logic       s_rst_n, s_stallF, s_stallD, s_clear;
    logic [5:0] s_imem_addr, s_imem_rdata, s_pcF, s_instrD, s_pcplus4D;
    logic [5:0] s_stall_cnt, s_flush_cnt;
    logic       s_validD, s_halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .clear(clear),
        .PCSrcD(PCSrcD), .jump(jump), .branch_target(branch_target),
        .jump_target(jump_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pcF(pcF), .instrD(instrD), .pcplus4D(pcplus4D), .validD(validD),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    fetch_stage #(.DATA_W(6), .RESET_PC(6'h00), .NOP_INSTR(6'h00)) dut_small (
        .clk(clk), .rst_n(s_rst_n), .stallF(s_stallF), .stallD(s_stallD), .clear(s_clear),
        .PCSrcD(1'b0), .jump(1'b0), .branch_target(6'h00), .jump_target(6'h00),
        .imem_addr(s_imem_addr), .imem_rdata(s_imem_rdata), .pcF(s_pcF),
        .instrD(s_instrD), .pcplus4D(s_pcplus4D), .validD(s_validD),
        .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Synchronous IMEMs whose contents equal the word address.
    always @(posedge clk) imem_rdata   <= imem_addr;
    always @(posedge clk) s_imem_rdata <= s_imem_addr;

    // Behavioural model of the main instance.
    logic [31:0] m_pc, m_instr, m_pcp4, m_stall, m_flush;
    logic        m_valid, m_halted;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] exp_fetch_addr();
        if (!rst_n)                 return 32'h0;
        if (stallF || m_halted)     return m_pc;
        if (jump)                   return jump_target;
        if (PCSrcD)                 return branch_target;
        return m_pc + 32'd4;
    endfunction

    task automatic model_step();
        logic [31:0] fetch_next;
        logic        halt_now;
        fetch_next = exp_fetch_addr();
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = NOP; m_pcp4 = 32'h4; m_valid = 1'b0;
            m_halted = 1'b0; m_stall = 32'h0; m_flush = 32'h0;
        end else begin
            halt_now = stallF && stallD && clear;
            if (!m_halted) begin
                if (stallF) m_stall = sat_inc(m_stall);
                if (!stallD) begin
                    m_instr = clear ? NOP : m_pc;   // IMEM word == address
                    m_valid = !clear;
                    m_pcp4  = m_pc + 32'd4;
                    if (clear) m_flush = sat_inc(m_flush);
                end
                m_pc = fetch_next;
            end
            m_halted = m_halted || halt_now;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check the combinational fetch address, take the edge,
    // advance the model, then compare every registered output.
    task automatic cycle();
        #1;
        check("imem_addr", imem_addr, exp_fetch_addr());
        @(posedge clk);
        model_step();
        #1;
        check("pcF", pcF, m_pc);
        check("instrD", instrD, m_instr);
        check("pcplus4D", pcplus4D, m_pcp4);
        check("validD", {31'b0, validD}, {31'b0, m_valid});
        check("halted", {31'b0, halted}, {31'b0, m_halted});
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic set_in(input logic sf, input logic sd, input logic cl, input logic ps,
                          input logic jp, input logic [31:0] bt, input logic [31:0] jt);
        stallF = sf; stallD = sd; clear = cl; PCSrcD = ps; jump = jp;
        branch_target = bt; jump_target = jt;
    endtask

    initial begin
        logic [31:0] frozen_pc, frozen_instr;

        rst_n = 1'b0; s_rst_n = 1'b0;
        s_stallF = 1'b0; s_stallD = 1'b0; s_clear = 1'b0;
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
        m_pc = 32'h0; m_instr = NOP; m_pcp4 = 32'h4; m_valid = 1'b0;
        m_halted = 1'b0; m_stall = 32'h0; m_flush = 32'h0;

        // Reset state.
        cycle(); cycle();
        check("reset_pcF", pcF, 32'h0);
        check("reset_pcplus4D", pcplus4D, 32'h4);
        check("reset_validD", {31'b0, validD}, 32'h0);

        // Free running from reset: pcF 0,4,8 with instrD one cycle behind.
        rst_n = 1'b1;
        cycle(); cycle();
        check("free_pcF", pcF, 32'h8);
        check("free_instrD", instrD, 32'h4);

        // Two-cycle stall holds PC and IF/ID.
        set_in(1, 1, 0, 0, 0, 32'h0, 32'h0);
        cycle(); cycle();
        check("stall_pcF", pcF, 32'h8);
        check("stall_instrD", instrD, 32'h4);
        check("stall_cnt_2", stall_cnt, 32'd2);
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
        cycle(); cycle();
        check("resume_pcF", pcF, 32'h10);

        // Taken branch with flush.
        set_in(0, 0, 1, 1, 0, 32'h40, 32'h0);
        cycle();
        check("branch_pcF", pcF, 32'h40);
        check("branch_bubble", instrD, NOP);
        check("flush_cnt_1", flush_cnt, 32'd1);
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
        cycle();
        check("branch_instrD", instrD, 32'h40);

        // Jump and branch together: jump wins.
        set_in(0, 0, 1, 1, 1, 32'h40, 32'h80);
        cycle();
        check("jump_wins", pcF, 32'h80);
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
        cycle();

        // Halt request, then ten frozen cycles.
        set_in(1, 1, 1, 0, 0, 32'h0, 32'h0);
        cycle();
        check("halt_set", {31'b0, halted}, 32'h1);
        frozen_pc = m_pc; frozen_instr = m_instr;
        set_in(0, 0, 0, 1, 1, 32'h40, 32'h100);
        for (int i = 0; i < 10; i++) cycle();
        check("halt_frozen_pc", pcF, frozen_pc);
        check("halt_frozen_instr", instrD, frozen_instr);

        // Reset clears the halt.
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
        cycle();
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);
        rst_n = 1'b1;

        // PC wrap at the top of the address space.
        set_in(0, 0, 1, 0, 1, 32'h0, 32'hFFFF_FFFC);
        cycle();
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
        cycle();
        check("wrap_pcF", pcF, 32'h0);
        check("wrap_pcplus4D", pcplus4D, 32'h0);

        // Saturation on the narrow instance.
        s_rst_n = 1'b1; s_stallF = 1'b1; s_stallD = 1'b1;
        for (int i = 0; i < 62; i++) cycle();
        check("sat_stall_62", {26'b0, s_stall_cnt}, 32'd62);
        cycle();
        check("sat_stall_63", {26'b0, s_stall_cnt}, 32'd63);
        for (int i = 0; i < 7; i++) cycle();
        check("sat_stall_hold", {26'b0, s_stall_cnt}, 32'd63);
        check("sat_not_halted", {31'b0, s_halted}, 32'h0);
        s_stallF = 1'b0; s_stallD = 1'b0; s_clear = 1'b1;
        for (int i = 0; i < 66; i++) cycle();
        check("sat_flush", {26'b0, s_flush_cnt}, 32'd63);
        check("small_wrap_pcF", {26'b0, s_pcF}, 32'd8);
        check("small_bubble", {31'b0, s_validD}, 32'h0);
        s_clear = 1'b0;

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            rst_n  = ($urandom_range(0, 49) != 0);
            stallF = ($urandom_range(0, 3) == 0);
            stallD = stallF ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 5) == 0);
            clear  = ($urandom_range(0, 3) == 0);
            jump   = ($urandom_range(0, 5) == 0);
            PCSrcD = ($urandom_range(0, 4) == 0);
            branch_target = $urandom() & 32'hFFFF_FFFC;
            jump_target   = $urandom() & 32'hFFFF_FFFC;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
